ysyx_22040759_divider: RTL and testbench
========================================

Name: ysyx_22040759_divider

Overview:
- Iterative radix-2 restoring divider for the EXU. It serves RV64M DIV/DIVU/REM/REMU and DIVW/DIVUW/REMW/REMUW.
- It replaces the single-cycle combinational divide path with a multi-cycle responder.
- The EXU is the initiator: it issues one request over a valid/ready handshake. The divider returns quotient and remainder over a second valid/ready handshake and holds them until the EXU accepts.

Parameters:
XLEN, 64, operand/result width
CNT_W, 7, iteration counter width (holds 0..XLEN)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  pipeline flush; abandons any in-flight operation
div_valid  in  1  request valid from EXU
div_ready  out  1  divider can accept a request
dividend  in  XLEN  operand a (rs1)
divisor  in  XLEN  operand b (rs2)
div_signed  in  1  1 = signed (DIV/REM), 0 = unsigned
div_word  in  1  1 = W variant: use bits [31:0], sign-extend results
res_valid  out  1  quotient/remainder valid
res_ready  in  1  EXU accepts the result
quotient  out  XLEN  quotient (already sign-extended in W mode)
remainder  out  XLEN  remainder (already sign-extended in W mode)

Behaviour:
- Reset values (async, rst_n low): state=IDLE, div_ready=1, res_valid=0, quotient=0, remainder=0, counter=0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - div_ready=1.
  - On div_valid && !flush, latch the operands, div_signed and div_word.
  - Go to DONE next cycle on a special case, otherwise to BUSY.
- Operand prep at accept:
  - W mode: take [31:0], sign-extend if div_signed, zero-extend otherwise. Width N=32.
  - Non-W: width N=64.
  - Signed: record sign_q = sa^sb and sign_r = sa. Divide the magnitudes |a|, |b|.
- Special cases, resolved at accept; DONE on the next cycle:
  - Divisor (low N bits) == 0: quotient = all ones, remainder = a.
  - Signed overflow (a = most-negative N-bit, b = -1): quotient = a, remainder = 0.
- BUSY:
  - One quotient bit per cycle, N cycles total, counter counting down from N.
  - Each cycle: shift partial remainder left by 1 bringing in the next dividend MSB, subtract the divisor. If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set it to 0.
  - After the last iteration, apply sign correction: negate the quotient if sign_q, negate the remainder if sign_r. Then go to DONE.
- Latency, accept to res_valid:
  - Normal: N+1 cycles (65 for 64-bit, 33 for W).
  - Special case: 1 cycle.
- DONE:
  - res_valid=1 and div_ready=0.
  - quotient/remainder are stable. W mode presents {32{r[31]}, r[31:0]}.
  - On res_ready, go to IDLE next cycle and drop res_valid. A new request is accepted no earlier than the cycle after the result handshake.
- Outputs hold their last value in IDLE. Do not rely on them when res_valid=0.
- flush:
  - Has priority over every other event in all states.
  - Next state = IDLE, res_valid=0. The pending result and partial state are discarded.
  - div_valid in the same cycle as flush is not accepted.
- div_ready is 0 in BUSY and DONE. Changing operand inputs during BUSY has no effect because the operands are latched.
- Reset asserted mid-operation aborts immediately with the reset values above.

Test Plan:
- Unsigned 64-bit: dividend=100, divisor=7, div_signed=0, div_word=0 -> after 65 cycles res_valid=1, quotient=14, remainder=2.
- Signed with negatives: dividend=-7 (0xFFFF_FFFF_FFFF_FFF9), divisor=2, signed -> quotient=-3, remainder=-1. Repeat with divisor=-2 -> quotient=3, remainder=-1.
- Divide by zero: dividend=0x1234, divisor=0, any mode -> res_valid 1 cycle after accept, quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=0x1234.
- Signed overflow:
  - 64-bit: dividend=0x8000_0000_0000_0000, divisor=-1 -> quotient=0x8000_0000_0000_0000, remainder=0.
  - DIVW: dividend=0x8000_0000, divisor=0xFFFF_FFFF -> quotient=0xFFFF_FFFF_8000_0000, remainder=0.
- W mode with upper-bit garbage: dividend=0xDEAD_BEEF_0000_0009, divisor=0xCAFE_0000_0000_0002, DIVUW -> 33-cycle latency, quotient=4, remainder=1. Then REMUW with dividend=0xFFFF_FFFF, divisor=1 -> remainder=0; with divisor=0x1_0000_0000 (W-divisor=0) -> remainder=0xFFFF_FFFF_FFFF_FFFF, the sign-extended a.
- Handshake and flush:
  - Hold res_ready=0 for 5 cycles in DONE -> res_valid and outputs stay stable, div_ready=0.
  - Assert flush at BUSY cycle 10 -> IDLE next cycle, res_valid never rises. A new request is accepted the following cycle and completes correctly.
  - Assert rst_n=0 mid-BUSY -> all outputs go to their reset values asynchronously.

Source files
------------

// File: rtl/ysyx_22040759_divider_if.sv
// Request/response bundle between the EXU (master) and the iterative divider (slave).
interface ysyx_22040759_divider_if #(
  parameter int unsigned XLEN = 64
);
  logic            flush;
  logic            div_valid;
  logic            div_ready;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            div_signed;
  logic            div_word;
  logic            res_valid;
  logic            res_ready;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;

  modport master (
    output flush, div_valid, dividend, divisor, div_signed, div_word, res_ready,
    input  div_ready, res_valid, quotient, remainder
  );

  modport slave (
    input  flush, div_valid, dividend, divisor, div_signed, div_word, res_ready,
    output div_ready, res_valid, quotient, remainder
  );
endinterface

// File: rtl/ysyx_22040759_divider.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and W variants.
// One quotient bit per cycle; divide-by-zero and signed overflow resolve at accept.
module ysyx_22040759_divider #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 7
) (
  input logic clk,
  input logic rst_n,
  ysyx_22040759_divider_if.slave bus
);
  localparam int unsigned HALF = XLEN / 2;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   prem_q, prem_d;   // partial remainder
  logic [XLEN-1:0]   dvd_q, dvd_d;     // dividend bits shift out the top, quotient bits shift in the bottom
  logic [XLEN-1:0]   dvs_q, dvs_d;     // divisor magnitude
  logic              word_q, word_d;
  logic              sgnq_q, sgnq_d;
  logic              sgnr_q, sgnr_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   rem_q, rem_d;

  logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, a_min;
  logic              a_neg, b_neg, div_zero, ovf;
  logic [XLEN:0]     shifted;
  logic              fits;
  logic [XLEN-1:0]   diff, prem_n, dvd_n;

  // Apply optional negation, then sign-extend from bit HALF-1 in W mode.
  function automatic logic [XLEN-1:0] fix(input logic [XLEN-1:0] v, input logic neg,
                                          input logic w);
    logic [XLEN-1:0] t;
    t = neg ? (~v + 1'b1) : v;
    return w ? {{HALF{t[HALF-1]}}, t[HALF-1:0]} : t;
  endfunction

  // Operand preparation: width select, extension, magnitudes and special-case detection.
  always_comb begin
    if (bus.div_word) begin
      a_ext = bus.div_signed ? {{HALF{bus.dividend[HALF-1]}}, bus.dividend[HALF-1:0]}
                             : {{HALF{1'b0}}, bus.dividend[HALF-1:0]};
      b_ext = bus.div_signed ? {{HALF{bus.divisor[HALF-1]}}, bus.divisor[HALF-1:0]}
                             : {{HALF{1'b0}}, bus.divisor[HALF-1:0]};
      a_min = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};
    end else begin
      a_ext = bus.dividend;
      b_ext = bus.divisor;
      a_min = {1'b1, {(XLEN-1){1'b0}}};
    end
    a_neg    = bus.div_signed & a_ext[XLEN-1];
    b_neg    = bus.div_signed & b_ext[XLEN-1];
    a_mag    = a_neg ? (~a_ext + 1'b1) : a_ext;
    b_mag    = b_neg ? (~b_ext + 1'b1) : b_ext;
    div_zero = (b_ext == '0);
    ovf      = bus.div_signed && (a_ext == a_min) && (b_ext == '1);
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted = {prem_q, dvd_q[XLEN-1]};
    fits    = (shifted >= {1'b0, dvs_q});
    diff    = shifted[XLEN-1:0] - dvs_q;
    prem_n  = fits ? diff : shifted[XLEN-1:0];
    dvd_n   = {dvd_q[XLEN-2:0], fits};
  end

  // Next-state and datapath update; flush overrides everything and keeps the old results.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    word_d  = word_q;
    sgnq_d  = sgnq_q;
    sgnr_d  = sgnr_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.div_valid) begin
            word_d = bus.div_word;
            sgnq_d = a_neg ^ b_neg;
            sgnr_d = a_neg;
            if (div_zero) begin
              quo_d   = '1;
              rem_d   = fix(a_ext, 1'b0, bus.div_word);
              state_d = DONE;
            end else if (ovf) begin
              quo_d   = fix(a_ext, 1'b0, bus.div_word);
              rem_d   = '0;
              state_d = DONE;
            end else begin
              // W operands are pre-aligned to the top so iteration always consumes bit XLEN-1.
              cnt_d   = bus.div_word ? CNT_W'(HALF) : CNT_W'(XLEN);
              prem_d  = '0;
              dvd_d   = bus.div_word ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;
              dvs_d   = b_mag;
              state_d = BUSY;
            end
          end
        end
        BUSY: begin
          prem_d = prem_n;
          dvd_d  = dvd_n;
          cnt_d  = cnt_q - 1'b1;
          // Sign correction is folded into the last step so BUSY lasts exactly N cycles.
          if (cnt_q == CNT_W'(1)) begin
            quo_d   = fix(dvd_n, sgnq_q, word_q);
            rem_d   = fix(prem_n, sgnr_q, word_q);
            state_d = DONE;
          end
        end
        DONE: begin
          if (bus.res_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      word_q  <= 1'b0;
      sgnq_q  <= 1'b0;
      sgnr_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      word_q  <= word_d;
      sgnq_q  <= sgnq_d;
      sgnr_q  <= sgnr_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  assign bus.div_ready = (state_q == IDLE);
  assign bus.res_valid = (state_q == DONE);
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
endmodule

// File: tb/tb_ysyx_22040759_divider.sv
// Self-checking bench for the iterative divider against an arithmetic reference model.
module tb_ysyx_22040759_divider;
  localparam int unsigned XLEN = 64;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_22040759_divider_if #(.XLEN(XLEN)) bus ();

  ysyx_22040759_divider #(.XLEN(XLEN), .CNT_W(7)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension semantics expressed with native arithmetic.
  function automatic void ref_div(input logic [63:0] a, input logic [63:0] b, input bit s,
                                  input bit w, output logic [63:0] q, output logic [63:0] r);
    logic signed [31:0] sa32, sb32;
    logic signed [63:0] sa64, sb64;
    logic [31:0] q32, r32;
    if (w) begin
      sa32 = a[31:0];
      sb32 = b[31:0];
      if (b[31:0] == 32'h0) begin
        q32 = '1; r32 = a[31:0];
      end else if (s && sa32 == 32'sh8000_0000 && sb32 == -32'sd1) begin
        q32 = a[31:0]; r32 = '0;
      end else if (s) begin
        q32 = sa32 / sb32; r32 = sa32 % sb32;
      end else begin
        q32 = a[31:0] / b[31:0]; r32 = a[31:0] % b[31:0];
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      sa64 = a;
      sb64 = b;
      if (b == 64'h0) begin
        q = '1; r = a;
      end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q = a; r = '0;
      end else if (s) begin
        q = sa64 / sb64; r = sa64 % sb64;
      end else begin
        q = a / b; r = a % b;
      end
    end
  endfunction

  // Called at a negedge; returns at a negedge with the divider back in IDLE.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input bit s, input bit w, input int hold);
    logic [63:0] eq, er;
    int lat, exp_lat;
    bit bz, ov;
    ref_div(a, b, s, w, eq, er);
    bz = w ? (b[31:0] == 32'h0) : (b == 64'h0);
    ov = s && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                 : (a == 64'h8000_0000_0000_0000 && b == '1));
    exp_lat = (bz || ov) ? 1 : (w ? 33 : 65);
    check({tag, "_ready"}, 64'(bus.div_ready), 64'd1);
    bus.dividend   = a;
    bus.divisor    = b;
    bus.div_signed = s;
    bus.div_word   = w;
    bus.div_valid  = 1'b1;
    @(negedge clk);
    bus.div_valid = 1'b0;
    bus.dividend  = {$urandom, $urandom};
    bus.divisor   = {$urandom, $urandom};
    bus.div_signed = ~s;
    bus.div_word   = ~w;
    lat = 1;
    while (!bus.res_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_q"}, bus.quotient, eq);
    check({tag, "_r"}, bus.remainder, er);
    check({tag, "_busy"}, 64'(bus.div_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_v"}, 64'(bus.res_valid), 64'd1);
      check({tag, "_hold_q"}, bus.quotient, eq);
      check({tag, "_hold_r"}, bus.remainder, er);
      check({tag, "_hold_rdy"}, 64'(bus.div_ready), 64'd0);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check({tag, "_drop"}, 64'(bus.res_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] a, b;
    bit s, w;
    int mode, rises;
    rst_n          = 1'b0;
    bus.flush      = 1'b0;
    bus.div_valid  = 1'b0;
    bus.res_ready  = 1'b0;
    bus.dividend   = '0;
    bus.divisor    = '0;
    bus.div_signed = 1'b0;
    bus.div_word   = 1'b0;
    #1;
    check("rst_ready", 64'(bus.div_ready), 64'd1);
    check("rst_valid", 64'(bus.res_valid), 64'd0);
    check("rst_q", bus.quotient, 64'd0);
    check("rst_r", bus.remainder, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("u64",     64'd100, 64'd7, 1'b0, 1'b0, 5);
    run_op("s64_p2",  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 0);
    run_op("s64_m2",  64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1);
    run_op("dz_u64",  64'h1234, 64'h0, 1'b0, 1'b0, 0);
    run_op("dz_s64",  64'h1234, 64'h0, 1'b1, 1'b0, 2);
    run_op("dz_sw",   64'h1234, 64'h0, 1'b1, 1'b1, 0);
    run_op("ovf64",   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 0);
    run_op("ovfw",    64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b1, 0);
    run_op("divuw",   64'hDEAD_BEEF_0000_0009, 64'hCAFE_0000_0000_0002, 1'b0, 1'b1, 0);
    run_op("remuw1",  64'hFFFF_FFFF, 64'd1, 1'b0, 1'b1, 0);
    run_op("remuw0",  64'hFFFF_FFFF, 64'h1_0000_0000, 1'b0, 1'b1, 0);

    // Flush mid-BUSY with a competing request that must be ignored.
    bus.dividend = 64'd12345; bus.divisor = 64'd11; bus.div_signed = 1'b0; bus.div_word = 1'b0;
    bus.div_valid = 1'b1;
    @(negedge clk);
    bus.div_valid = 1'b0;
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    bus.div_valid = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.div_valid = 1'b0;
    check("flush_valid", 64'(bus.res_valid), 64'd0);
    check("flush_idle", 64'(bus.div_ready), 64'd1);
    run_op("post_flush", 64'hFFFF_FFFF_FFFF_FF00, 64'd5, 1'b1, 1'b0, 0);
    rises = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (bus.res_valid) rises++;
    end
    check("flush_quiet", 64'(rises), 64'd0);

    // Asynchronous reset mid-BUSY.
    bus.dividend = 64'd999; bus.divisor = 64'd4; bus.div_signed = 1'b0; bus.div_word = 1'b0;
    bus.div_valid = 1'b1;
    @(negedge clk);
    bus.div_valid = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", 64'(bus.div_ready), 64'd1);
    check("arst_valid", 64'(bus.res_valid), 64'd0);
    check("arst_q", bus.quotient, 64'd0);
    check("arst_r", bus.remainder, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post_rst", 64'd1000, 64'd3, 1'b0, 1'b0, 0);

    // Randomized operations across all modes.
    for (int n = 0; n < 40; n++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} >> $urandom_range(0, 63);
      s = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 9);
      if (mode == 0) begin
        b = w ? {$urandom, 32'h0} : 64'h0;
      end else if (mode == 1) begin
        s = 1'b1;
        a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
        b = w ? {$urandom, 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
      end else if (mode == 2) begin
        b = 64'($urandom_range(1, 20));
        if ($urandom_range(0, 1) == 1) b = ~b + 64'd1;
      end
      run_op($sformatf("rnd%0d", n), a, b, s, w, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
